// File: rtl/wb_comp_pkg.sv
// Shared constants for the cw link compressor: bus widths, word-0 layout, FSM encoding.
// The responder-side decompressor decodes word 0 with these same constants.
package wb_comp_pkg;

    localparam int unsigned RW          = 16;
    localparam int unsigned WB_ADDR_W   = 24;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned ADRH_W      = 8;
    localparam int unsigned SEL_LSB     = 14;
    localparam int unsigned ADRH_LSB    = 0;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ADR  = 3'd2,
        S_WDAT = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_e;

    // Wishbone request captured at acceptance
    typedef struct packed {
        logic [SEL_W-1:0]     sel;
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [RW-1:0]        dat;
    } wb_req_t;

    // Word 0: byte-lane select in the top bits, address high byte in the bottom
    function automatic logic [RW-1:0] hdr_word(input logic [SEL_W-1:0]  sel,
                                               input logic [ADRH_W-1:0] adr_hi);
        logic [RW-1:0] w;
        w = '0;
        w[SEL_LSB +: SEL_W]   = sel;
        w[ADRH_LSB +: ADRH_W] = adr_hi;
        return w;
    endfunction

endpackage

// File: rtl/wb_comp.sv
// Initiator-side cw link compressor: serialises one classic Wishbone request into
// header/address/data words on the 16-bit link and returns the responder's ack/err.
module wb_comp
    import wb_comp_pkg::*;
#(
    parameter int unsigned ADDR_W  = WB_ADDR_W,
    parameter int unsigned DATA_W  = RW,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              d_clk,
    input  logic              i_rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_i_dat,
    output logic [DATA_W-1:0] wb_o_dat,
    output logic              wb_ack,
    output logic              wb_err,
    output logic              cw_clk,
    output logic [DATA_W-1:0] cw_io_o,
    input  logic [DATA_W-1:0] cw_io_i,
    output logic              cw_req,
    output logic              cw_dir,
    input  logic              cw_ack,
    input  logic              cw_err
);

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    wb_req_t            req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               cw_req_q, cw_req_d;
    logic               cw_dir_q, cw_dir_d;
    logic [DATA_W-1:0]  cw_io_o_q, cw_io_o_d;
    logic [DATA_W-1:0]  wb_o_dat_q, wb_o_dat_d;
    logic               wb_ack_q, wb_ack_d;
    logic               wb_err_q, wb_err_d;

    logic [WB_ADDR_W-1:0] adr_in_c;
    logic                 abort_now_c;

    assign adr_in_c    = WB_ADDR_W'(wb_adr);
    // A master that drops cyc mid-transfer loses its response, but the link still finishes
    assign abort_now_c = abort_q | ~wb_cyc;

    assign cw_clk   = d_clk;
    assign cw_io_o  = cw_io_o_q;
    assign cw_req   = cw_req_q;
    assign cw_dir   = cw_dir_q;
    assign wb_o_dat = wb_o_dat_q;
    assign wb_ack   = wb_ack_q;
    assign wb_err   = wb_err_q;

    // Next state and the registered outputs for the cycle being entered
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        cw_req_d   = 1'b0;
        cw_dir_d   = 1'b0;
        cw_io_o_d  = '0;
        wb_o_dat_d = wb_o_dat_q;
        wb_ack_d   = 1'b0;
        wb_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    req_d.sel = wb_sel;
                    req_d.we  = wb_we;
                    req_d.adr = adr_in_c;
                    req_d.dat = RW'(wb_i_dat);
                    abort_d   = 1'b0;
                    state_d   = S_HDR;
                    cw_req_d  = 1'b1;
                    cw_dir_d  = wb_we;
                    cw_io_o_d = DATA_W'(hdr_word(wb_sel, adr_in_c[WB_ADDR_W-1 -: ADRH_W]));
                end
            end
            S_HDR: begin
                abort_d   = abort_now_c;
                state_d   = S_ADR;
                cw_req_d  = 1'b1;
                cw_dir_d  = req_q.we;
                cw_io_o_d = DATA_W'(req_q.adr[15:0]);
            end
            S_ADR: begin
                abort_d = abort_now_c;
                if (req_q.we) begin
                    state_d   = S_WDAT;
                    cw_req_d  = 1'b1;
                    cw_dir_d  = 1'b1;
                    cw_io_o_d = DATA_W'(req_q.dat);
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WDAT: begin
                abort_d = abort_now_c;
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                abort_d = abort_now_c;
                if (cw_err) begin
                    state_d  = S_RESP;
                    wb_err_d = ~abort_now_c;
                end else if (cw_ack) begin
                    state_d  = S_RESP;
                    wb_ack_d = ~abort_now_c;
                    if (!req_q.we) begin
                        wb_o_dat_d = cw_io_i;
                    end
                end else if (cnt_q == TMO_CNT) begin
                    state_d  = S_RESP;
                    wb_err_d = ~abort_now_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge d_clk) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            cw_req_q   <= 1'b0;
            cw_dir_q   <= 1'b0;
            cw_io_o_q  <= '0;
            wb_o_dat_q <= '0;
            wb_ack_q   <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            cw_req_q   <= cw_req_d;
            cw_dir_q   <= cw_dir_d;
            cw_io_o_q  <= cw_io_o_d;
            wb_o_dat_q <= wb_o_dat_d;
            wb_ack_q   <= wb_ack_d;
            wb_err_q   <= wb_err_d;
        end
    end

endmodule

// File: doc/wb_comp.md
# wb_comp

Initiator-side compressor for the core's narrow cw bus: accepts a single-master classic Wishbone request and serialises it onto the 16-bit cw link. It waits for the responder's acknowledge and returns read data or an error to the Wishbone master. It sits at the core end of the link, mirroring the responder-side decompressor in the SoC, and is clocked by the core clock.

## Interface
Parameters:
- ADDR_W, 24, Wishbone address width (`WB_ADDR_W`).
- DATA_W, 16, data and cw word width (`RW`).
- TIMEOUT, 255, maximum WAIT cycles before an error is reported; range 1..255, 8-bit counter.

Ports:
- d_clk  in  1  core clock; all logic on posedge.
- i_rst  in  1  reset, synchronous, active-low; clock d_clk.
- wb_cyc  in  1  Wishbone cycle.
- wb_stb  in  1  Wishbone strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  ADDR_W  byte/word address.
- wb_sel  in  2  byte lane select.
- wb_i_dat  in  DATA_W  write data from master.
- wb_o_dat  out  DATA_W  read data to master, registered.
- wb_ack  out  1  one-cycle transfer-complete pulse.
- wb_err  out  1  one-cycle error pulse.
- cw_clk  out  1  link clock, driven directly from d_clk.
- cw_io_o  out  DATA_W  link word to responder, registered.
- cw_io_i  in  DATA_W  link word from responder (read data).
- cw_req  out  1  high while request words are on cw_io_o.
- cw_dir  out  1  1 = write, valid while cw_req is high.
- cw_ack  in  1  responder completion; cw_io_i is valid in the same cycle.
- cw_err  in  1  responder error.

## Operation
- States: IDLE, HDR (word 0), ADR (word 1), WDAT (word 2, writes only), WAIT, RESP.
- IDLE: on wb_cyc & wb_stb, latch adr/we/sel/dat and go to HDR.
- Word 0 is {sel[1:0], 6'b0, adr[23:16]}. Word 1 is adr[15:0]. Word 2 is the write data.
- HDR -> ADR. ADR -> WDAT if we, else -> WAIT. WDAT -> WAIT.
- cw_req=1 and cw_dir=we during HDR, ADR and WDAT. cw_req=0 otherwise.
- WAIT:
  - cw_ack: latch cw_io_i into wb_o_dat (reads only; writes leave wb_o_dat unchanged), go to RESP with ack.
  - cw_err: go to RESP with err.
  - If both are asserted in the same cycle, cw_err wins.
- The timeout counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT with no cw_ack/cw_err, go to RESP with err.
- RESP: wb_ack or wb_err is high for exactly this cycle, then IDLE.
- cw_ack/cw_err outside WAIT are ignored.
- Abort: if wb_cyc is low at any point after acceptance, set an abort flag. The cw transaction still completes (the link has no cancel), but wb_ack/wb_err are suppressed in RESP. wb_o_dat is still updated.
- Reset (i_rst=0 at an edge): state=IDLE. Reset values: cw_req=0, cw_dir=0, cw_io_o=0, wb_o_dat=0, wb_ack=0, wb_err=0, counter=0, abort=0. Takes effect on the next edge even mid-transfer.

## Timing
- Let E0 be the edge where the request is accepted in IDLE.
- Word 0 is on the link in cycle E0+1, word 1 in E0+2, word 2 (writes) in E0+3.
- Read: WAIT starts at E0+3. With the earliest cw_ack at E0+3, wb_ack is high at E0+4, giving a minimum latency of 4 cycles.
- Write: WAIT starts at E0+4, giving a minimum wb_ack at E0+5.
- Timeout: err is asserted TIMEOUT+1 cycles after WAIT entry.
- The cycle after RESP is IDLE and can accept a new request, so a master holding stb high gets back-to-back transfers with one idle-link gap.
- wb_o_dat is stable from the RESP cycle until the next read completes.

## Structure
- Shared config.v/package holds: `RW`, `WB_ADDR_W`, state encoding, word-0 field offsets (SEL_LSB=14, ADRH_LSB=0), default TIMEOUT.
- The responder must decode word 0 with the same constants.
- Single flat module with no sub-module. The FSM plus an 8-bit counter is small enough.

## Test plan
- Read adr=24'h123456, sel=2'b11, responder acks 2 cycles into WAIT with cw_io_i=16'hBEEF -> link words 16'hC012, 16'h3456; cw_dir=0; wb_ack one cycle with wb_o_dat=16'hBEEF.
- Write adr=24'hFFE010, sel=2'b01, dat=16'hA55A, immediate cw_ack -> words 16'h40FF, 16'hE010, 16'hA55A; cw_dir=1; wb_ack at E0+5.
- Read with responder silent, TIMEOUT=4 -> wb_err pulse 5 cycles after WAIT entry; wb_ack never asserted; returns to IDLE.
- cw_ack and cw_err asserted together in WAIT -> wb_err=1, wb_ack=0.
- wb_cyc dropped during ADR of a read, responder acks -> cw words complete, no wb_ack/wb_err, next request accepted normally.
- i_rst=0 during WDAT -> next edge cw_req=0, cw_io_o=0, wb_ack=0; then a fresh read completes correctly.
